c4_shift_sequencer: RTL

//   Multi-cycle shift engine; complements the single-step combinational shifter.

---
 rtl/c4_shift_sequencer_pkg.sv | 36 +++
 rtl/c4_shift_sequencer_if.sv | 31 +++
 rtl/c4_shift_sequencer_step.sv | 51 +++++
 rtl/c4_shift_sequencer.sv | 110 +++++++++++
 4 files changed

// File: rtl/c4_shift_sequencer_pkg.sv
// ============================================================================
// c4_shift_sequencer_pkg : opcode and state encodings for the shift sequencer
// Revision: 1.0
// ============================================================================
`default_nettype none

package c4_shift_sequencer_pkg;

  typedef enum logic [2:0] {
    OP_PASS = 3'b000,
    OP_LSL  = 3'b001,
    OP_LSR  = 3'b010,
    OP_ROL  = 3'b011,
    OP_ROR  = 3'b100,
    OP_ASR  = 3'b101
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_e;

  // Codes 110/111 fall through to PASS along with 000.
  function automatic logic is_pass(input logic [2:0] op);
    logic r;
    case (op)
      OP_LSL, OP_LSR, OP_ROL, OP_ROR, OP_ASR: r = 1'b0;
      default:                                r = 1'b1;
    endcase
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/c4_shift_sequencer_if.sv
// ============================================================================
// c4_shift_sequencer_if : request/result bundle of the shift sequencer
// Revision: 1.0
// ============================================================================
`default_nettype none

interface c4_shift_sequencer_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
);
  logic             start;
  logic [WIDTH-1:0] data_in;
  logic [2:0]       op;
  logic [CNT_W-1:0] amount;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] data_out;
  logic             carry_out;

  modport master (
    output start, data_in, op, amount,
    input  busy, done, data_out, carry_out
  );

  modport slave (
    input  start, data_in, op, amount,
    output busy, done, data_out, carry_out
  );
endinterface

`default_nettype wire

// File: rtl/c4_shift_sequencer_step.sv
// ============================================================================
// c4_shift_sequencer_step : combinational single bit-step of the work register
// Revision: 1.0
// ============================================================================
`default_nettype none

module c4_shift_sequencer_step
  import c4_shift_sequencer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  wire logic [WIDTH-1:0] w_i,
  input  wire logic [2:0]       op_i,
  output logic      [WIDTH-1:0] w_o,
  output logic                  c_o
);

  always_comb begin
    w_o = w_i;
    c_o = 1'b0;
    case (op_i)
      OP_LSL: begin
        w_o = {w_i[WIDTH-2:0], 1'b0};
        c_o = w_i[WIDTH-1];
      end
      OP_LSR: begin
        w_o = {1'b0, w_i[WIDTH-1:1]};
        c_o = w_i[0];
      end
      OP_ROL: begin
        w_o = {w_i[WIDTH-2:0], w_i[WIDTH-1]};
        c_o = w_i[WIDTH-1];
      end
      OP_ROR: begin
        w_o = {w_i[0], w_i[WIDTH-1:1]};
        c_o = w_i[0];
      end
      OP_ASR: begin
        w_o = {w_i[WIDTH-1], w_i[WIDTH-1:1]};
        c_o = w_i[0];
      end
      default: begin
        w_o = w_i;
        c_o = 1'b0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/c4_shift_sequencer.sv
// ============================================================================
// c4_shift_sequencer : multi-cycle shifter, one bit-step per clock, start/done
// Revision: 1.0
// ============================================================================
`default_nettype none

module c4_shift_sequencer
  import c4_shift_sequencer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input wire logic              clk,
  input wire logic              rst_n,
  c4_shift_sequencer_if.slave   bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] w_q, w_d;
  logic [2:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             c_q, c_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             carry_out_q, carry_out_d;

  logic [WIDTH-1:0] w_step;
  logic             c_step;

  c4_shift_sequencer_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .w_i  (w_q),
    .op_i (op_q),
    .w_o  (w_step),
    .c_o  (c_step)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      w_q         <= '0;
      op_q        <= OP_PASS;
      cnt_q       <= '0;
      c_q         <= 1'b0;
      data_out_q  <= '0;
      carry_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      w_q         <= w_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      c_q         <= c_d;
      data_out_q  <= data_out_d;
      carry_out_q <= carry_out_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    w_d         = w_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    c_d         = c_q;
    data_out_d  = data_out_q;
    carry_out_d = carry_out_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          w_d   = bus.data_in;
          op_d  = bus.op;
          cnt_d = bus.amount;
          c_d   = 1'b0;
          if ((bus.amount == '0) || is_pass(bus.op)) begin
            state_d     = S_DONE;
            data_out_d  = bus.data_in;
            carry_out_d = 1'b0;
          end else begin
            state_d = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        w_d   = w_step;
        c_d   = c_step;
        cnt_d = cnt_q - CNT_W'(1);
        // Outputs are loaded with the final step's value as DONE is entered.
        if (cnt_q <= CNT_W'(1)) begin
          state_d     = S_DONE;
          data_out_d  = w_step;
          carry_out_d = c_step;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = (state_q == S_DONE);
  assign bus.data_out  = data_out_q;
  assign bus.carry_out = carry_out_q;

endmodule

`default_nettype wire
